// File: rtl/zube_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : zube_pkg
// Description : Definitions shared by the zube Z80 front end and the mailbox
//               core: front-end FSM state encoding, default I/O decode and
//               the port offsets of the mailbox register map.
// Revision    : 1.0 - initial release
// ============================================================================
package zube_pkg;

  // Front-end cycle FSM.
  typedef enum logic [2:0] {
    ST_RELEASE    = 3'd0,
    ST_IDLE       = 3'd1,
    ST_WRITE      = 3'd2,
    ST_READ_REQ   = 3'd3,
    ST_READ_DRIVE = 3'd4
  } state_t;

  // Default I/O decode: ports 0x00..0x03.
  localparam logic [7:0] ZUBE_PORT_BASE = 8'h00;
  localparam logic [7:0] ZUBE_PORT_MASK = 8'hFC;

  // Port offsets within the claimed window, as seen by the mailbox core.
  localparam logic [1:0] PORT_Z80_DATA = 2'd0;
  localparam logic [1:0] PORT_DATA     = 2'd1;
  localparam logic [1:0] PORT_STATUS   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/zube_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : zube_sync
// Description : Multi-bit, STAGES-deep flip-flop synchroniser for
//               asynchronous Z80 pins. Each bit is synchronised
//               independently; RESET_VALUE sets the reset contents of every
//               stage.
// Ports       : clk      - destination clock
//               reset_b  - asynchronous active-low reset
//               d        - asynchronous input vector
//               q        - synchronised output vector
// Revision    : 1.0 - initial release
// ============================================================================
module zube_sync
  import zube_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/zube_z80_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : zube_z80_frontend
// Description : Z80-side front end of the zube mailbox. Synchronises the Z80
//               pins into the wishbone clock domain, decodes qualified I/O
//               read/write cycles into single-cycle mailbox strobes, and
//               drives the Z80 data bus for the remainder of a read cycle.
// Ports       : clk                 - wishbone clock (>= 4x Z80 clock)
//               reset_b             - asynchronous active-low reset
//               z80_address_bus     - Z80 A[7:0] (async)
//               z80_data_bus_in     - Z80 D[7:0] input (async)
//               z80_data_bus_out    - read data driven to the Z80
//               z80_bus_dir         - 1 = drive the Z80 data bus
//               z80_read_strobe_b   - Z80 /RD (async)
//               z80_write_strobe_b  - Z80 /WR (async)
//               z80_m1              - Z80 /M1 (async)
//               z80_ioreq_b         - Z80 /IORQ (async)
//               io_addr             - port offset of the current cycle
//               io_wr_data          - captured write data
//               io_wr_stb           - one-cycle write request
//               io_rd_stb           - one-cycle read request
//               io_rd_data          - mailbox read data (cycle after rd_stb)
//               bus_err             - sticky /RD+/WR conflict flag
// Revision    : 1.0 - initial release
// ============================================================================
module zube_z80_frontend
  import zube_pkg::*;
#(
  parameter logic [7:0] PORT_BASE   = ZUBE_PORT_BASE,
  parameter logic [7:0] PORT_MASK   = ZUBE_PORT_MASK,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic [7:0] z80_address_bus,
  input  logic [7:0] z80_data_bus_in,
  output logic [7:0] z80_data_bus_out,
  output logic       z80_bus_dir,
  input  logic       z80_read_strobe_b,
  input  logic       z80_write_strobe_b,
  input  logic       z80_m1,
  input  logic       z80_ioreq_b,
  output logic [1:0] io_addr,
  output logic [7:0] io_wr_data,
  output logic       io_wr_stb,
  output logic       io_rd_stb,
  input  logic [7:0] io_rd_data,
  output logic       bus_err
);

  // --------------------------------------------------------------------------
  // Pin synchronisers
  // --------------------------------------------------------------------------
  logic [3:0]  ctrl_s;
  logic [15:0] addr_data_s;

  zube_sync #(
    .WIDTH       (4),
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (4'hF)
  ) u_sync_ctrl (
    .clk     (clk),
    .reset_b (reset_b),
    .d       ({z80_ioreq_b, z80_m1, z80_write_strobe_b, z80_read_strobe_b}),
    .q       (ctrl_s)
  );

  zube_sync #(
    .WIDTH       (16),
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (16'h0000)
  ) u_sync_addr_data (
    .clk     (clk),
    .reset_b (reset_b),
    .d       ({z80_address_bus, z80_data_bus_in}),
    .q       (addr_data_s)
  );

  logic       ioreq_b_s;
  logic       m1_s;
  logic       wr_b_s;
  logic       rd_b_s;
  logic [7:0] addr_s;
  logic [7:0] data_s;

  assign ioreq_b_s = ctrl_s[3];
  assign m1_s      = ctrl_s[2];
  assign wr_b_s    = ctrl_s[1];
  assign rd_b_s    = ctrl_s[0];
  assign addr_s    = addr_data_s[15:8];
  assign data_s    = addr_data_s[7:0];

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic       match;
  logic [1:0] offset;

  assign match  = ((addr_s & PORT_MASK) == (PORT_BASE & PORT_MASK));
  assign offset = addr_s[1:0] & ~PORT_MASK[1:0];

  // The control synchronisers reset to "inactive", so for the first
  // SYNC_STAGES cycles after reset they report an idle bus regardless of the
  // pins. RELEASE must not trust them until the pipeline holds real samples,
  // otherwise a cycle already in flight at reset release would be actioned.
  logic [1:0] prime_q;
  logic       primed;

  assign primed = (prime_q == 2'(SYNC_STAGES));

  // --------------------------------------------------------------------------
  // FSM and datapath
  // --------------------------------------------------------------------------
  state_t     state_q,   state_d;
  logic [1:0] addr_q,    addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_stb_q,  wr_stb_d;
  logic       rd_stb_q,  rd_stb_d;
  logic [7:0] bus_out_q, bus_out_d;
  logic       bus_dir_q, bus_dir_d;
  logic       err_q,     err_d;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= ST_RELEASE;
      prime_q   <= 2'd0;
      addr_q    <= 2'd0;
      wr_data_q <= 8'h00;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      bus_out_q <= 8'h00;
      bus_dir_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (!primed) begin
        prime_q <= prime_q + 2'd1;
      end
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      bus_out_q <= bus_out_d;
      bus_dir_q <= bus_dir_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    wr_stb_d  = 1'b0;
    rd_stb_d  = 1'b0;
    bus_out_d = bus_out_q;
    bus_dir_d = bus_dir_q;
    err_d     = err_q;

    case (state_q)
      // Wait for the bus to go fully idle so that each Z80 cycle produces at
      // most one request, however long the strobes are held.
      ST_RELEASE: begin
        if (primed && ioreq_b_s && rd_b_s && wr_b_s) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (!rd_b_s && !wr_b_s) begin
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end else if (!ioreq_b_s) begin
          if (!m1_s) begin
            // Interrupt acknowledge: never claimed.
            state_d = ST_RELEASE;
          end else if (!wr_b_s) begin
            if (match) begin
              addr_d    = offset;
              wr_data_d = data_s;
              state_d   = ST_WRITE;
            end else begin
              state_d = ST_RELEASE;
            end
          end else if (!rd_b_s) begin
            if (match) begin
              addr_d  = offset;
              state_d = ST_READ_REQ;
            end else begin
              state_d = ST_RELEASE;
            end
          end
          // /IORQ low with neither strobe yet visible (pin skew through the
          // synchronisers): keep waiting in IDLE.
        end
      end

      ST_WRITE: begin
        wr_stb_d = 1'b1;
        state_d  = ST_RELEASE;
      end

      ST_READ_REQ: begin
        rd_stb_d = 1'b1;
        state_d  = ST_READ_DRIVE;
      end

      // io_rd_data is valid the cycle after the strobe, so capture waits
      // until the strobe register has dropped, then drives until the Z80
      // ends the cycle.
      ST_READ_DRIVE: begin
        if (rd_b_s || ioreq_b_s) begin
          bus_dir_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (!bus_dir_q && !rd_stb_q) begin
          bus_out_d = io_rd_data;
          bus_dir_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_RELEASE;
      end
    endcase
  end

  assign z80_data_bus_out = bus_out_q;
  assign z80_bus_dir      = bus_dir_q;
  assign io_addr          = addr_q;
  assign io_wr_data       = wr_data_q;
  assign io_wr_stb        = wr_stb_q;
  assign io_rd_stb        = rd_stb_q;
  assign bus_err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_zube_z80_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_zube_z80_frontend
// Description : Self-checking bench for zube_z80_frontend. A table of Z80
//               I/O cycles with hand-computed expectations, followed by
//               hand-written reset-during-read and back-to-back sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zube_z80_frontend;

  localparam int SYNC = 2;

  localparam int K_OUT  = 0;
  localparam int K_IN   = 1;
  localparam int K_INTA = 2;
  localparam int K_BOTH = 3;

  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] din = 8'h00;
  logic       rd_b = 1'b1;
  logic       wr_b = 1'b1;
  logic       m1_b = 1'b1;
  logic       ioreq_b = 1'b1;
  logic [7:0] io_rd_data = 8'h00;
  logic [7:0] mbox_val = 8'h00;

  logic [7:0] z80_data_bus_out;
  logic       z80_bus_dir;
  logic [1:0] io_addr;
  logic [7:0] io_wr_data;
  logic       io_wr_stb;
  logic       io_rd_stb;
  logic       bus_err;

  zube_z80_frontend #(
    .PORT_BASE   (8'h00),
    .PORT_MASK   (8'hFC),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk                (clk),
    .reset_b            (reset_b),
    .z80_address_bus    (addr),
    .z80_data_bus_in    (din),
    .z80_data_bus_out   (z80_data_bus_out),
    .z80_bus_dir        (z80_bus_dir),
    .z80_read_strobe_b  (rd_b),
    .z80_write_strobe_b (wr_b),
    .z80_m1             (m1_b),
    .z80_ioreq_b        (ioreq_b),
    .io_addr            (io_addr),
    .io_wr_data         (io_wr_data),
    .io_wr_stb          (io_wr_stb),
    .io_rd_stb          (io_rd_stb),
    .io_rd_data         (io_rd_data),
    .bus_err            (bus_err)
  );

  always #5 clk = ~clk;

  // Mailbox model: read data is valid only in the cycle after io_rd_stb.
  always @(posedge clk) begin
    io_rd_data <= io_rd_stb ? mbox_val : 8'hEE;
  end

  // --------------------------------------------------------------------------
  // Monitor: sampled 1 ns after each rising edge
  // --------------------------------------------------------------------------
  int         cyc = 0;
  int         wr_cnt, rd_cnt, wr_cyc, rd_cyc, dir_rise_cyc, dir_fall_cyc;
  logic [1:0] wr_addr_seen, rd_addr_seen;
  logic [7:0] wr_data_seen, bus_seen;
  logic [7:0] wlog_data [$];
  logic [1:0] wlog_addr [$];
  logic       dir_prev = 1'b0;
  int         edge_cyc, rel_cyc;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (io_wr_stb) begin
      wr_cnt++;
      wr_cyc       = cyc;
      wr_addr_seen = io_addr;
      wr_data_seen = io_wr_data;
      wlog_data.push_back(io_wr_data);
      wlog_addr.push_back(io_addr);
    end
    if (io_rd_stb) begin
      rd_cnt++;
      rd_cyc       = cyc;
      rd_addr_seen = io_addr;
    end
    if (z80_bus_dir && !dir_prev) begin
      dir_rise_cyc = cyc;
      bus_seen     = z80_data_bus_out;
    end
    if (!z80_bus_dir && dir_prev) begin
      dir_fall_cyc = cyc;
    end
    dir_prev = z80_bus_dir;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wr_cnt = 0; rd_cnt = 0; wr_cyc = -1; rd_cyc = -1;
    dir_rise_cyc = -1; dir_fall_cyc = -1;
    wr_addr_seen = 2'd0; rd_addr_seen = 2'd0;
    wr_data_seen = 8'h00; bus_seen = 8'h00;
    wlog_data.delete();
    wlog_addr.delete();
  endtask

  task automatic start_cycle(input int kind, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr     = a;
    din      = d;
    m1_b     = (kind == K_INTA) ? 1'b0 : 1'b1;
    ioreq_b  = 1'b0;
    rd_b     = (kind == K_IN  || kind == K_BOTH) ? 1'b0 : 1'b1;
    wr_b     = (kind == K_OUT || kind == K_BOTH) ? 1'b0 : 1'b1;
    edge_cyc = cyc;
  endtask

  task automatic end_cycle();
    @(negedge clk);
    rd_b    = 1'b1;
    wr_b    = 1'b1;
    ioreq_b = 1'b1;
    m1_b    = 1'b1;
    rel_cyc = cyc;
  endtask

  typedef struct {
    int         kind;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rdval;
    int         hold;
    int         exp_wr;
    int         exp_rd;
    logic [1:0] exp_addr;
    logic [7:0] exp_wdata;
    logic [7:0] exp_bus;
    logic       exp_err;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;

    //               kind    addr   data   rdval  hold wr rd addr  wdata  bus    err
    vecs[0] = '{K_OUT,  8'h01, 8'hA5, 8'h00, 40, 1, 0, 2'd1, 8'hA5, 8'h00, 1'b0};
    vecs[1] = '{K_IN,   8'h02, 8'h00, 8'h3C, 12, 0, 1, 2'd2, 8'h00, 8'h3C, 1'b0};
    vecs[2] = '{K_IN,   8'h40, 8'h00, 8'h55, 12, 0, 0, 2'd0, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{K_INTA, 8'h00, 8'hFF, 8'h55, 12, 0, 0, 2'd0, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{K_OUT,  8'h03, 8'h5A, 8'h00,  8, 1, 0, 2'd3, 8'h5A, 8'h00, 1'b0};
    vecs[5] = '{K_BOTH, 8'h01, 8'h12, 8'h00, 12, 0, 0, 2'd0, 8'h00, 8'h00, 1'b1};
    vecs[6] = '{K_OUT,  8'h00, 8'h77, 8'h00, 10, 1, 0, 2'd0, 8'h77, 8'h00, 1'b1};
    vecs[7] = '{K_IN,   8'h03, 8'h00, 8'hC3, 20, 0, 1, 2'd3, 8'h00, 8'hC3, 1'b1};
    vecs[8] = '{K_OUT,  8'hFD, 8'h99, 8'h00,  8, 0, 0, 2'd0, 8'h00, 8'h00, 1'b1};

    clear_mon();

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_dir",     {31'd0, z80_bus_dir}, 0);
    check("reset_wr_stb",  {31'd0, io_wr_stb},   0);
    check("reset_rd_stb",  {31'd0, io_rd_stb},   0);
    check("reset_bus_out", {24'd0, z80_data_bus_out}, 0);
    check("reset_io_addr", {30'd0, io_addr},     0);
    check("reset_wr_data", {24'd0, io_wr_data},  0);
    check("reset_bus_err", {31'd0, bus_err},     0);
    reset_b = 1'b1;
    repeat (10) @(negedge clk);

    // Table-driven Z80 cycles
    for (int i = 0; i < NVEC; i++) begin
      clear_mon();
      mbox_val = vecs[i].rdval;
      start_cycle(vecs[i].kind, vecs[i].a, vecs[i].d);
      repeat (vecs[i].hold - 1) @(negedge clk);
      end_cycle();
      repeat (12) @(negedge clk);

      check($sformatf("v%0d_wr_cnt", i), wr_cnt, vecs[i].exp_wr);
      check($sformatf("v%0d_rd_cnt", i), rd_cnt, vecs[i].exp_rd);
      if (vecs[i].exp_wr != 0) begin
        check($sformatf("v%0d_wr_addr", i), {30'd0, wr_addr_seen}, {30'd0, vecs[i].exp_addr});
        check($sformatf("v%0d_wr_data", i), {24'd0, wr_data_seen}, {24'd0, vecs[i].exp_wdata});
        check($sformatf("v%0d_wr_latency", i), wr_cyc - edge_cyc, SYNC + 2);
      end
      if (vecs[i].exp_rd != 0) begin
        check($sformatf("v%0d_rd_addr", i), {30'd0, rd_addr_seen}, {30'd0, vecs[i].exp_addr});
        check($sformatf("v%0d_rd_latency", i), rd_cyc - edge_cyc, SYNC + 2);
        check($sformatf("v%0d_dir_after_stb", i), dir_rise_cyc - rd_cyc, 2);
        check($sformatf("v%0d_bus_data", i), {24'd0, bus_seen}, {24'd0, vecs[i].exp_bus});
        check($sformatf("v%0d_dir_release_ok", i),
              {31'd0, (dir_fall_cyc > rel_cyc) && (dir_fall_cyc - rel_cyc <= SYNC + 1)}, 1);
        check($sformatf("v%0d_bus_hold", i), {24'd0, z80_data_bus_out}, {24'd0, vecs[i].exp_bus});
      end else begin
        check($sformatf("v%0d_no_dir", i), dir_rise_cyc, -1);
      end
      check($sformatf("v%0d_bus_err", i), {31'd0, bus_err}, {31'd0, vecs[i].exp_err});
    end

    // Reset pulsed while driving a read, /RD still low afterwards
    clear_mon();
    mbox_val = 8'h99;
    start_cycle(K_IN, 8'h02, 8'h00);
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      if (z80_bus_dir) got = 1;
    end
    check("rst_mid_read_dir_reached", got, 1);
    reset_b = 1'b0;
    #1;
    check("rst_mid_read_dir",     {31'd0, z80_bus_dir}, 0);
    check("rst_mid_read_rd_stb",  {31'd0, io_rd_stb},   0);
    check("rst_mid_read_bus_err", {31'd0, bus_err},     0);
    check("rst_mid_read_bus_out", {24'd0, z80_data_bus_out}, 0);
    @(negedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    clear_mon();
    repeat (15) @(negedge clk);
    check("rst_held_no_strobe", wr_cnt + rd_cnt, 0);
    check("rst_held_no_dir",    dir_rise_cyc, -1);
    end_cycle();
    repeat (8) @(negedge clk);
    clear_mon();
    start_cycle(K_OUT, 8'h01, 8'hB4);
    repeat (9) @(negedge clk);
    end_cycle();
    repeat (12) @(negedge clk);
    check("rst_fresh_wr_cnt",  wr_cnt, 1);
    check("rst_fresh_rd_cnt",  rd_cnt, 0);
    check("rst_fresh_wr_data", {24'd0, wr_data_seen}, 32'hB4);

    // Back-to-back OUTs, 2 Z80 clocks (8 clk) of idle bus between them
    clear_mon();
    start_cycle(K_OUT, 8'h01, 8'h11);
    repeat (9) @(negedge clk);
    end_cycle();
    repeat (7) @(negedge clk);
    start_cycle(K_OUT, 8'h02, 8'h22);
    repeat (9) @(negedge clk);
    end_cycle();
    repeat (12) @(negedge clk);
    check("b2b_wr_cnt", wr_cnt, 2);
    check("b2b_data0",  {24'd0, wlog_data[0]}, 32'h11);
    check("b2b_addr0",  {30'd0, wlog_addr[0]}, 1);
    check("b2b_data1",  {24'd0, wlog_data[1]}, 32'h22);
    check("b2b_addr1",  {30'd0, wlog_addr[1]}, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
